// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts RV32I field bundles, encodes them and streams the
// words into instruction memory from base_addr, one per cycle, for load_len writes.
module instr_encoder_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_kind,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic              sub_sra,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    localparam logic [2:0] K_LOAD = 3'd0, K_STORE = 3'd1, K_RTYPE = 3'd2, K_BRANCH = 3'd3,
                           K_ITYPE = 3'd4, K_JAL = 3'd5, K_LUI = 3'd6, K_ILLEGAL = 3'd7;
    localparam logic [ADDR_W-1:0] L_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_acc;
    logic [ADDR_W-1:0] r_wcnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic              w_hs;
    logic              w_legal;
    logic              w_last;
    logic [31:0]       w_enc;

    // r_acc counts legal handshakes, r_wcnt completed writes; they differ by the one in flight
    assign op_ready    = (r_state == S_RUN) && (r_acc < r_len);
    assign w_hs        = op_valid && op_ready;
    assign w_legal     = op_kind != K_ILLEGAL;
    assign w_last      = r_we && ((r_wcnt + L_ONE) == r_len);
    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign busy        = r_state == S_RUN;
    assign done        = r_state == S_DONE;
    assign err_illegal = r_err;

    always_comb begin
        w_enc = 32'h0;
        case (op_kind)
            K_LOAD:   w_enc = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            K_ITYPE:  w_enc = {imm[11:0], rs1, funct3, rd, 7'b0010011};
            K_STORE:  w_enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            K_RTYPE:  w_enc = {1'b0, sub_sra, 5'b00000, rs2, rs1, funct3, rd, 7'b0110011};
            K_BRANCH: w_enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            K_JAL:    w_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            K_LUI:    w_enc = {imm[31:12], rd, 7'b0110111};
            default:  w_enc = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_ptr   <= '0;
            r_acc   <= '0;
            r_wcnt  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_we <= w_hs && w_legal;
            if (w_hs && w_legal) begin
                r_addr  <= r_ptr;
                r_wdata <= w_enc;
                r_ptr   <= r_ptr + L_ONE;
                r_acc   <= r_acc + L_ONE;
            end
            if (w_hs && !w_legal)
                r_err <= 1'b1;
            if (r_we)
                r_wcnt <= r_wcnt + L_ONE;
            if (r_state != S_RUN && start) begin
                r_len   <= load_len;
                r_ptr   <= base_addr;
                r_acc   <= '0;
                r_wcnt  <= '0;
                r_err   <= 1'b0;
                r_state <= (load_len == '0) ? S_DONE : S_RUN;
            end else if (w_last) begin
                r_state <= S_DONE;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized self-checking bench with an arithmetic RV32I
// encoder model and an address/ordering scoreboard for the loader.
module tb_instr_encoder_loader;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] load_len = '0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [2:0]    op_kind = '0;
    logic [4:0]    rd = '0;
    logic [4:0]    rs1 = '0;
    logic [4:0]    rs2 = '0;
    logic [2:0]    funct3 = '0;
    logic          sub_sra = 1'b0;
    logic [31:0]   imm = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err_illegal;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .load_len(load_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind), .rd(rd), .rs1(rs1),
        .rs2(rs2), .funct3(funct3), .sub_sra(sub_sra), .imm(imm), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        ss;
        logic [31:0] imm;
    } op_t;

    int            n_checks = 0;
    int            n_fail = 0;
    op_t           ops[$];
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    int            obs_cyc[$];
    int            done_cyc;
    int            bad_timing;
    int            first_err;
    bit            timed_out;

    function automatic logic [31:0] ref_enc(input op_t o);
        logic [31:0] im = o.imm;
        logic [31:0] d  = 32'(o.rd) << 7;
        logic [31:0] f  = 32'(o.f3) << 12;
        logic [31:0] a  = 32'(o.rs1) << 15;
        logic [31:0] b  = 32'(o.rs2) << 20;
        case (o.kind)
            3'd0: return ((im & 32'hFFF) << 20) | a | f | d | 32'h03;
            3'd4: return ((im & 32'hFFF) << 20) | a | f | d | 32'h13;
            3'd1: return (((im >> 5) & 32'h7F) << 25) | b | a | f | ((im & 32'h1F) << 7) | 32'h23;
            3'd2: return (32'(o.ss) << 30) | b | a | f | d | 32'h33;
            3'd3: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | b | a | f
                         | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'h63;
            3'd5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                         | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | d | 32'h6F;
            3'd6: return (im & 32'hFFFFF000) | d | 32'h37;
            default: return 32'h0;
        endcase
    endfunction

    function automatic op_t rand_op(input int kmax);
        op_t o;
        o.kind = 3'($urandom_range(0, kmax));
        o.rd   = 5'($urandom);
        o.rs1  = 5'($urandom);
        o.rs2  = 5'($urandom);
        o.f3   = 3'($urandom);
        o.ss   = 1'($urandom);
        o.imm  = $urandom;
        return o;
    endfunction

    function automatic op_t mk(input logic [2:0] k, input logic [4:0] d, input logic [4:0] a,
                               input logic [4:0] b, input logic [2:0] f, input logic s,
                               input logic [31:0] i);
        op_t o;
        o.kind = k; o.rd = d; o.rs1 = a; o.rs2 = b; o.f3 = f; o.ss = s; o.imm = i;
        return o;
    endfunction

    task automatic drive_op(input op_t o);
        op_kind = o.kind; rd = o.rd; rs1 = o.rs1; rs2 = o.rs2;
        funct3 = o.f3; sub_sra = o.ss; imm = o.imm;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
        start = 1'b1; base_addr = b; load_len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers ops[] with the given valid probability and records every write; a start is pulsed at cycle start_at.
    task automatic stream(input int valid_pct, input int start_at);
        int idx = 0;
        int cyc = 0;
        bit hs;
        bit legal;
        bit seen_hs = 0;
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
        done_cyc = -1; bad_timing = 0; first_err = -1; timed_out = 1;
        while (cyc < 3000) begin
            op_valid = (idx < ops.size()) && ($urandom_range(0, 99) < valid_pct);
            drive_op(op_valid ? ops[idx] : rand_op(7));
            start = (cyc == start_at);
            if (start) begin
                base_addr = AW'($urandom);
                load_len  = 1;
            end
            hs    = op_valid && op_ready;
            legal = hs && (op_kind != 3'd7);
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (hs) idx++;
            if (imem_we !== legal) bad_timing++;
            if (imem_we === 1'b1) begin
                obs_addr.push_back(imem_addr);
                obs_data.push_back(imem_wdata);
                obs_cyc.push_back(cyc);
            end
            if (hs && !seen_hs) begin
                seen_hs = 1;
                first_err = int'(err_illegal);
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                timed_out = 0;
                break;
            end
        end
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if ({op_ready, imem_we, busy, done, err_illegal} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000", {op_ready, imem_we, busy, done, err_illegal});
        end
        n_checks++;
        if ({imem_addr, imem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr %h data %h expected 0", imem_addr, imem_wdata);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_encoding();
        logic [31:0] want[8] = '{32'h00500093, 32'h0040A103, 32'h0020A423, 32'h002081B3,
                                 32'h402081B3, 32'h00208463, 32'h010000EF, 32'h123452B7};
        ops.delete();
        ops.push_back(mk(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5));
        ops.push_back(mk(3'd0, 5'd2, 5'd1, 5'd0, 3'd2, 1'b0, 32'd4));
        ops.push_back(mk(3'd1, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8));
        ops.push_back(mk(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0));
        ops.push_back(mk(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0));
        ops.push_back(mk(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8));
        ops.push_back(mk(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd16));
        ops.push_back(mk(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000));
        do_start(10'h000, 10'd8);
        n_checks++;
        if ({busy, op_ready, done} !== 3'b110) begin
            n_fail++;
            $display("FAIL enc_run_state: got busy/ready/done %b expected 110", {busy, op_ready, done});
        end
        stream(100, -1);
        n_checks++;
        if (obs_addr.size() != 8 || timed_out) begin
            n_fail++;
            $display("FAIL enc_count: got %0d writes (timeout %0d) expected 8", obs_addr.size(), timed_out);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (i >= obs_addr.size() || obs_addr[i] !== AW'(i) || obs_data[i] !== want[i]) begin
                n_fail++;
                $display("FAIL enc_word%0d: got %h@%h expected %h@%h", i,
                         (i < obs_data.size()) ? obs_data[i] : 32'hx,
                         (i < obs_addr.size()) ? obs_addr[i] : {AW{1'bx}}, want[i], AW'(i));
            end
        end
        n_checks++;
        if (obs_cyc.size() != 8 || obs_cyc[7] - obs_cyc[0] != 7 || done_cyc != obs_cyc[7] + 1) begin
            n_fail++;
            $display("FAIL enc_timing: got first %0d last %0d done %0d expected span 7 and done=last+1",
                     (obs_cyc.size() > 0) ? obs_cyc[0] : -1,
                     (obs_cyc.size() > 0) ? obs_cyc[obs_cyc.size()-1] : -1, done_cyc);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] b = AW'($urandom);
        int k = 0;
        int bad = 0;
        ops.delete();
        for (int i = 0; i < 27; i++) ops.push_back(rand_op(6));
        do_start(b, 10'd24);
        stream(50, -1);
        for (int i = 0; i < 24; i++) begin
            if (i >= obs_addr.size() || obs_addr[i] !== AW'(b + i) || obs_data[i] !== ref_enc(ops[i]))
                bad++;
        end
        k = obs_addr.size();
        n_checks++;
        if (k != 24 || timed_out) begin
            n_fail++;
            $display("FAIL bp_count: got %0d writes (timeout %0d) expected 24", k, timed_out);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_words: got %0d wrong writes expected 0", bad);
        end
        n_checks++;
        if (bad_timing != 0) begin
            n_fail++;
            $display("FAIL bp_timing: got %0d cycles with write/handshake misalignment expected 0", bad_timing);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] want[3] = '{10'h3FE, 10'h3FF, 10'h000};
        ops.delete();
        for (int i = 0; i < 3; i++) ops.push_back(rand_op(6));
        do_start(10'h3FE, 10'd3);
        stream(80, -1);
        n_checks++;
        if (obs_addr.size() != 3 || timed_out) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes expected 3", obs_addr.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= obs_addr.size() || obs_addr[i] !== want[i] || obs_data[i] !== ref_enc(ops[i])) begin
                n_fail++;
                $display("FAIL wrap_word%0d: got addr %h expected %h", i,
                         (i < obs_addr.size()) ? obs_addr[i] : {AW{1'bx}}, want[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [AW-1:0] b = AW'($urandom);
        op_t o;
        ops.delete();
        o = rand_op(6); o.kind = 3'd7; ops.push_back(o);
        o = rand_op(6); o.kind = 3'd4; ops.push_back(o);
        o = rand_op(6); o.kind = 3'd6; ops.push_back(o);
        do_start(b, 10'd2);
        stream(100, -1);
        n_checks++;
        if (first_err != 1) begin
            n_fail++;
            $display("FAIL ill_flag_first: got %0d expected 1", first_err);
        end
        n_checks++;
        if (obs_addr.size() != 2 || timed_out) begin
            n_fail++;
            $display("FAIL ill_count: got %0d writes expected 2", obs_addr.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= obs_addr.size() || obs_addr[i] !== AW'(b + i) || obs_data[i] !== ref_enc(ops[i+1])) begin
                n_fail++;
                $display("FAIL ill_word%0d: got %h@%h expected %h@%h", i,
                         (i < obs_data.size()) ? obs_data[i] : 32'hx,
                         (i < obs_addr.size()) ? obs_addr[i] : {AW{1'bx}}, ref_enc(ops[i+1]), AW'(b + i));
            end
        end
        n_checks++;
        if (err_illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL ill_sticky: got %b expected 1", err_illegal);
        end
        do_start(AW'($urandom), 10'd0);
        n_checks++;
        if ({err_illegal, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL ill_clear: got err/done %b expected 01", {err_illegal, done});
        end
    endtask

    task automatic test_zero_len_restart();
        logic [AW-1:0] b = AW'($urandom);
        int seen = 0;
        do_start(AW'($urandom), 10'd0);
        n_checks++;
        if ({busy, done, op_ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL zero_state: got busy/done/ready %b expected 010", {busy, done, op_ready});
        end
        for (int i = 0; i < 5; i++) begin
            op_valid = 1'b1;
            drive_op(rand_op(6));
            if (op_ready !== 1'b0) seen++;
            @(posedge clk); #1;
            if (imem_we !== 1'b0) seen++;
        end
        op_valid = 1'b0;
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL zero_activity: got %0d ready/write events expected 0", seen);
        end
        ops.delete();
        for (int i = 0; i < 4; i++) ops.push_back(rand_op(6));
        do_start(b, 10'd4);
        stream(70, 2);
        n_checks++;
        if (obs_addr.size() != 4 || timed_out) begin
            n_fail++;
            $display("FAIL restart_count: got %0d writes expected 4", obs_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= obs_addr.size() || obs_addr[i] !== AW'(b + i) || obs_data[i] !== ref_enc(ops[i])) begin
                n_fail++;
                $display("FAIL restart_word%0d: got addr %h expected %h", i,
                         (i < obs_addr.size()) ? obs_addr[i] : {AW{1'bx}}, AW'(b + i));
            end
        end
    endtask

    task automatic test_reset_abort();
        do_start(AW'($urandom), 10'd5);
        op_valid = 1'b1;
        drive_op(rand_op(6));
        @(posedge clk); #1;
        op_valid = 1'b0;
        n_checks++;
        if (imem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre_write: got %b expected 1", imem_we);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({op_ready, imem_we, busy, done, err_illegal, imem_addr, imem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got we %b busy %b addr %h data %h expected all 0",
                     imem_we, busy, imem_addr, imem_wdata);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({imem_we, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_hold: got we/busy/done %b expected 000", {imem_we, busy, done});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({op_ready, imem_we, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_idle: got ready/we/busy/done %b expected 0000", {op_ready, imem_we, busy, done});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_encoding();
        test_backpressure();
        test_wrap();
        test_illegal();
        test_zero_len_restart();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, instruction-memory word-address width.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-005 Port: base_addr  input  ADDR_W  first word address, sampled on accepted start.
REQ-006 Port: load_len  input  ADDR_W  number of instructions to write, sampled on accepted start.
REQ-007 Port: op_valid  input  1  an instruction field bundle is presented.
REQ-008 Port: op_ready  output  1  encoder accepts the bundle this cycle.
REQ-009 Port: op_kind  input  3  0 LOAD, 1 STORE, 2 R_TYPE, 3 BRANCH, 4 I_TYPE, 5 JAL, 6 LUI, 7 illegal.
REQ-010 Port: rd, rs1, rs2  input  5 each  register fields.
REQ-011 Port: funct3  input  3  funct3 field, for example 010 for a word access or 001 for BNE.
REQ-012 Port: sub_sra  input  1  drives funct7 bit 5 for R_TYPE.
REQ-013 Port: imm  input  32  immediate, byte offset, or upper value, depending on op_kind.
REQ-014 Port: imem_we  output  1  one-cycle write strobe to instruction memory.
REQ-015 Port: imem_addr  output  ADDR_W  word address of the write.
REQ-016 Port: imem_wdata  output  32  encoded RV32I instruction word.
REQ-017 Port: busy  output  1  high in RUN.
REQ-018 Port: done  output  1  high in DONE.
REQ-019 Port: err_illegal  output  1  sticky flag set by an illegal op_kind.

Function
REQ-020 FSM states:
- IDLE -> RUN on start when load_len != 0.
- IDLE -> DONE on start when load_len == 0.
- RUN -> DONE on the cycle of the write that brings the written count to load_len.
- DONE -> RUN or DONE on a new start, by the same load_len rule as from IDLE.
REQ-021 op_ready SHALL be 1 only in RUN while accepted count < load_len; handshake = op_valid & op_ready.
REQ-022 Pipelining: a handshake in cycle N SHALL produce imem_we=1 in cycle N+1 with registered imem_addr and imem_wdata.
REQ-023 Throughput SHALL be one instruction per cycle.
REQ-024 imem_we SHALL be 0 in every cycle without a preceding legal handshake.
REQ-025 Encodings, by op_kind:
- LOAD, opcode 0000011: {imm[11:0], rs1, funct3, rd, opcode}.
- I_TYPE, opcode 0010011: {imm[11:0], rs1, funct3, rd, opcode}.
- STORE, opcode 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- R_TYPE, opcode 0110011: {0, sub_sra, 00000, rs2, rs1, funct3, rd, opcode}.
- BRANCH, opcode 1100011: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- JAL, opcode 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- LUI, opcode 0110111: {imm[31:12], rd, opcode}.
REQ-026 Unused imm bits SHALL be ignored; imm[0] SHALL be ignored for BRANCH and JAL.
REQ-027 Illegal op_kind: the handshake completes, no write occurs, the address and written count do not advance, and err_illegal is set.
REQ-028 err_illegal SHALL clear only on reset or on an accepted start.
REQ-029 imem_addr SHALL start at base_addr and increment by 1 after each write, wrapping modulo 2^ADDR_W.
REQ-030 start SHALL be ignored in RUN, with no effect on state, address, or counts.
REQ-031 start and a handshake SHALL never coincide, because op_ready=0 outside RUN.

Reset
REQ-032 While rst_n=0:
- State SHALL be IDLE.
- op_ready, imem_we, busy, done, and err_illegal SHALL be 0.
- imem_addr, imem_wdata, and all counters SHALL be 0.
REQ-033 Reset asserted mid-load SHALL abort the load immediately, with no further writes, including any write pending from the last handshake.

Verification
REQ-034 Encoding check: start with base=0 and len=8, then supply the sequence below. Required:
- Writes to addresses 0..7, on consecutive cycles.
- done=1 in the cycle after the 8th write.

| Instruction | Required word |
|---|---|
| addi x1,x0,5 | 0x00500093 |
| lw x2,4(x1) | 0x0040A103 |
| sw x2,8(x1) | 0x0020A423 |
| add x3,x1,x2 | 0x002081B3 |
| sub x3,x1,x2 | 0x402081B3 |
| beq x1,x2,+8 | 0x00208463 |
| jal x1,+16 | 0x010000EF |
| lui x5,0x12345 | 0x123452B7 |

REQ-035 Backpressure: toggle op_valid randomly. Required: writes occur exactly one cycle after each handshake, and no writes occur in gap cycles.
REQ-036 Wrap-around: start with base=0x3FE and len=3. Required: writes at 0x3FE, 0x3FF, 0x000.
REQ-037 Illegal kind: start with len=2 and supply kind 7, kind 4, kind 6. Required:
- err_illegal=1 after the first handshake.
- Exactly 2 writes, at base and base+1.
- err_illegal clears on the next start.
REQ-038 Zero length and restart: start with len=0. Required: DONE next cycle, op_ready never 1, no writes. A start pulsed during RUN SHALL be ignored.
REQ-039 Reset abort: assert rst_n=0 during the cycle after a handshake. Required: imem_we=0, all outputs 0, state IDLE.
